// File: rtl/calculator_pkg.sv
// Shared sizing constants for the calculator memory subsystem.
//   ADDR_W        : width of memory word addresses
//   MEM_WORD_SIZE : width of one memory word in bits
package calculator_pkg;
    localparam int ADDR_W        = 4;
    localparam int MEM_WORD_SIZE = 64;
endpackage

// File: rtl/calc_mem_responder.sv
// calc_mem_responder
// Word-addressed memory that answers read/write strobes from the calculator
// controller. After reset it zeroes every implemented word (one per cycle)
// before raising ready. Reads have one cycle of latency and are write-first on
// a same-address collision. Accesses to addresses >= DEPTH are flagged through
// a sticky err/err_addr pair; accepted strobes are counted with saturation.
//
// Ports
//   clk_i, rst_ni            : clock, asynchronous active-low reset
//   read, r_addr             : read strobe and address
//   r_data, r_valid          : registered read data, one-cycle valid pulse
//   write, w_addr, w_data    : write strobe, address and data
//   ready                    : memory cleared and accepting accesses
//   err, err_addr, err_clr   : sticky out-of-range flag, first bad address, clear
//   rd_count, wr_count       : saturating accepted read/write counters
module calc_mem_responder
    import calculator_pkg::*;
#(
    parameter int DEPTH = 2**ADDR_W,
    parameter int CNT_W = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     read,
    input  logic [ADDR_W-1:0]        r_addr,
    output logic [MEM_WORD_SIZE-1:0] r_data,
    output logic                     r_valid,
    input  logic                     write,
    input  logic [ADDR_W-1:0]        w_addr,
    input  logic [MEM_WORD_SIZE-1:0] w_data,
    output logic                     ready,
    output logic                     err,
    output logic [ADDR_W-1:0]        err_addr,
    input  logic                     err_clr,
    output logic [CNT_W-1:0]         rd_count,
    output logic [CNT_W-1:0]         wr_count
);
    localparam int                IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0]   DEPTH_L  = (ADDR_W+1)'(DEPTH);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DEPTH - 1);

    typedef enum logic {S_CLEAR, S_READY} state_e;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    state_e                   state_q,    state_d;
    logic [IDX_W-1:0]         clr_ptr_q,  clr_ptr_d;
    logic [MEM_WORD_SIZE-1:0] r_data_q,   r_data_d;
    logic                     r_valid_q,  r_valid_d;
    logic                     err_q,      err_d;
    logic [ADDR_W-1:0]        err_addr_q, err_addr_d;
    logic [CNT_W-1:0]         rd_count_q, rd_count_d;
    logic [CNT_W-1:0]         wr_count_q, wr_count_d;

    logic [MEM_WORD_SIZE-1:0] mem_q [DEPTH];
    logic                     mem_we;
    logic [IDX_W-1:0]         mem_widx;
    logic [MEM_WORD_SIZE-1:0] mem_wdata;

    logic rd_in, wr_in, rd_acc, wr_acc, rd_oor, wr_oor;

    assign rd_in  = ({1'b0, r_addr} < DEPTH_L);
    assign wr_in  = ({1'b0, w_addr} < DEPTH_L);
    assign rd_acc = (state_q == S_READY) && read;
    assign wr_acc = (state_q == S_READY) && write;
    assign rd_oor = rd_acc && !rd_in;
    assign wr_oor = wr_acc && !wr_in;

    always_comb begin
        state_d    = state_q;
        clr_ptr_d  = clr_ptr_q;
        r_data_d   = r_data_q;
        r_valid_d  = 1'b0;
        rd_count_d = rd_count_q;
        wr_count_d = wr_count_q;
        mem_we     = 1'b0;
        mem_widx   = clr_ptr_q;
        mem_wdata  = '0;

        case (state_q)
            S_CLEAR: begin
                mem_we = 1'b1;
                if (clr_ptr_q == LAST_IDX) begin
                    state_d = S_READY;
                end else begin
                    clr_ptr_d = clr_ptr_q + 1'b1;
                end
            end
            S_READY: begin
                if (wr_acc) begin
                    wr_count_d = sat_inc(wr_count_q);
                    if (wr_in) begin
                        mem_we    = 1'b1;
                        mem_widx  = w_addr[IDX_W-1:0];
                        mem_wdata = w_data;
                    end
                end
                if (rd_acc) begin
                    r_valid_d  = 1'b1;
                    rd_count_d = sat_inc(rd_count_q);
                    if (!rd_in) begin
                        r_data_d = '0;
                    end else if (wr_acc && wr_in && (w_addr == r_addr)) begin
                        // Write-first: forward the data being written this cycle.
                        r_data_d = w_data;
                    end else begin
                        r_data_d = mem_q[r_addr[IDX_W-1:0]];
                    end
                end
            end
            default: state_d = S_CLEAR;
        endcase
    end

    // Error capture: a clear and a new error in the same cycle leaves the new
    // error standing, so the clear is applied first and the capture overrides.
    always_comb begin
        err_d      = err_q;
        err_addr_d = err_addr_q;
        if (err_clr) begin
            err_d      = 1'b0;
            err_addr_d = '0;
        end
        if (rd_oor || wr_oor) begin
            err_d = 1'b1;
            if (!err_q || err_clr) begin
                err_addr_d = rd_oor ? r_addr : w_addr;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= S_CLEAR;
            clr_ptr_q  <= '0;
            r_data_q   <= '0;
            r_valid_q  <= 1'b0;
            err_q      <= 1'b0;
            err_addr_q <= '0;
            rd_count_q <= '0;
            wr_count_q <= '0;
        end else begin
            state_q    <= state_d;
            clr_ptr_q  <= clr_ptr_d;
            r_data_q   <= r_data_d;
            r_valid_q  <= r_valid_d;
            err_q      <= err_d;
            err_addr_q <= err_addr_d;
            rd_count_q <= rd_count_d;
            wr_count_q <= wr_count_d;
        end
    end

    // Storage is not reset; the clear sequence zeroes it before ready rises.
    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            mem_q[mem_widx] <= mem_wdata;
        end
    end

    assign ready    = (state_q == S_READY);
    assign r_data   = r_data_q;
    assign r_valid  = r_valid_q;
    assign err      = err_q;
    assign err_addr = err_addr_q;
    assign rd_count = rd_count_q;
    assign wr_count = wr_count_q;

endmodule

// File: tb/tb_calc_mem_responder.sv
module tb_calc_mem_responder;
    import calculator_pkg::*;

    logic                     clk_i = 1'b0;
    logic                     rst_ni = 1'b0;
    logic                     read = 1'b0;
    logic [ADDR_W-1:0]        r_addr = '0;
    logic                     write = 1'b0;
    logic [ADDR_W-1:0]        w_addr = '0;
    logic [MEM_WORD_SIZE-1:0] w_data = '0;
    logic                     err_clr = 1'b0;

    logic [MEM_WORD_SIZE-1:0] r_data, r_data4;
    logic                     r_valid, r_valid4, ready, ready4, err, err4;
    logic [ADDR_W-1:0]        err_addr, err_addr4;
    logic [15:0]              rd_count, wr_count;
    logic [3:0]               rd_count4, wr_count4;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk_i = ~clk_i;

    calc_mem_responder #(.DEPTH(12), .CNT_W(16)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .read(read), .r_addr(r_addr), .r_data(r_data), .r_valid(r_valid),
        .write(write), .w_addr(w_addr), .w_data(w_data),
        .ready(ready), .err(err), .err_addr(err_addr), .err_clr(err_clr),
        .rd_count(rd_count), .wr_count(wr_count)
    );

    calc_mem_responder #(.DEPTH(12), .CNT_W(4)) dut4 (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .read(read), .r_addr(r_addr), .r_data(r_data4), .r_valid(r_valid4),
        .write(write), .w_addr(w_addr), .w_data(w_data),
        .ready(ready4), .err(err4), .err_addr(err_addr4), .err_clr(err_clr),
        .rd_count(rd_count4), .wr_count(wr_count4)
    );

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        read = 1'b0; write = 1'b0; err_clr = 1'b0;
        r_addr = '0; w_addr = '0; w_data = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_ni = 1'b0;
        tick();
        rst_ni = 1'b1;
        repeat (12) tick();
    endtask

    task automatic test_reset();
        #2;
        n_checks++;
        if (r_data !== '0 || r_valid !== 1'b0 || ready !== 1'b0 || err !== 1'b0 ||
            err_addr !== '0 || rd_count !== '0 || wr_count !== '0) begin
            n_errors++;
            $display("FAIL reset_outputs: r_data=%h r_valid=%b ready=%b err=%b err_addr=%0d rd=%0d wr=%0d, required all zero",
                     r_data, r_valid, ready, err, err_addr, rd_count, wr_count);
        end
        tick();
        rst_ni = 1'b1;
        for (int i = 0; i < 12; i++) begin
            n_checks++;
            if (ready !== 1'b0) begin
                n_errors++;
                $display("FAIL clear_ready_low cycle %0d: ready=%b required 0", i + 1, ready);
            end
            tick();
        end
        n_checks++;
        if (ready !== 1'b1) begin
            n_errors++;
            $display("FAIL ready_cycle13: ready=%b required 1", ready);
        end
        for (int a = 0; a < 12; a++) begin
            read = 1'b1; r_addr = ADDR_W'(a);
            tick();
            n_checks++;
            if (r_valid !== 1'b1 || r_data !== '0) begin
                n_errors++;
                $display("FAIL cleared_word addr %0d: r_valid=%b r_data=%h required 1 / 0", a, r_valid, r_data);
            end
        end
        read = 1'b0;
        tick();
        n_checks++;
        if (r_valid !== 1'b0 || rd_count !== 16'd12) begin
            n_errors++;
            $display("FAIL after_sweep: r_valid=%b rd_count=%0d required 0 / 12", r_valid, rd_count);
        end
    endtask

    task automatic test_write_read();
        do_reset();
        write = 1'b1; w_addr = 4'd3; w_data = 64'h1122_3344_5566_7788;
        tick();
        write = 1'b0;
        n_checks++;
        if (r_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL write_no_valid: r_valid=%b required 0", r_valid);
        end
        read = 1'b1; r_addr = 4'd3;
        tick();
        read = 1'b0;
        n_checks++;
        if (r_valid !== 1'b1 || r_data !== 64'h1122_3344_5566_7788) begin
            n_errors++;
            $display("FAIL write_read: r_valid=%b r_data=%h required 1 / 1122334455667788", r_valid, r_data);
        end
        tick();
        n_checks++;
        if (r_valid !== 1'b0 || r_data !== 64'h1122_3344_5566_7788) begin
            n_errors++;
            $display("FAIL read_hold: r_valid=%b r_data=%h required 0 / 1122334455667788", r_valid, r_data);
        end
    endtask

    task automatic test_same_cycle();
        do_reset();
        write = 1'b1; w_addr = 4'd5; w_data = 64'hAA;
        read = 1'b1; r_addr = 4'd5;
        tick();
        idle_inputs();
        n_checks++;
        if (r_valid !== 1'b1 || r_data !== 64'hAA || wr_count !== 16'd1 || rd_count !== 16'd1) begin
            n_errors++;
            $display("FAIL write_first: r_valid=%b r_data=%h wr=%0d rd=%0d required 1 / aa / 1 / 1",
                     r_valid, r_data, wr_count, rd_count);
        end
        write = 1'b1; w_addr = 4'd7; w_data = 64'h1234;
        read = 1'b1; r_addr = 4'd5;
        tick();
        idle_inputs();
        n_checks++;
        if (r_data !== 64'hAA) begin
            n_errors++;
            $display("FAIL diff_addr_read: r_data=%h required aa", r_data);
        end
        read = 1'b1; r_addr = 4'd7;
        tick();
        idle_inputs();
        n_checks++;
        if (r_data !== 64'h1234 || wr_count !== 16'd2 || rd_count !== 16'd3) begin
            n_errors++;
            $display("FAIL diff_addr_write: r_data=%h wr=%0d rd=%0d required 1234 / 2 / 3", r_data, wr_count, rd_count);
        end
    endtask

    task automatic test_out_of_range();
        do_reset();
        write = 1'b1; w_addr = 4'd2; w_data = 64'h55;
        tick();
        idle_inputs();
        read = 1'b1; r_addr = 4'd2;
        tick();
        idle_inputs();
        n_checks++;
        if (r_data !== 64'h55 || err !== 1'b0) begin
            n_errors++;
            $display("FAIL oor_setup: r_data=%h err=%b required 55 / 0", r_data, err);
        end
        write = 1'b1; w_addr = 4'd14; w_data = 64'hDEAD;
        tick();
        idle_inputs();
        n_checks++;
        if (err !== 1'b1 || err_addr !== 4'd14 || wr_count !== 16'd2) begin
            n_errors++;
            $display("FAIL oor_write: err=%b err_addr=%0d wr=%0d required 1 / 14 / 2", err, err_addr, wr_count);
        end
        read = 1'b1; r_addr = 4'd13;
        tick();
        idle_inputs();
        n_checks++;
        if (r_valid !== 1'b1 || r_data !== '0 || err_addr !== 4'd14 || rd_count !== 16'd2) begin
            n_errors++;
            $display("FAIL oor_read: r_valid=%b r_data=%h err_addr=%0d rd=%0d required 1 / 0 / 14 / 2",
                     r_valid, r_data, err_addr, rd_count);
        end
        err_clr = 1'b1;
        tick();
        idle_inputs();
        n_checks++;
        if (err !== 1'b0 || err_addr !== '0) begin
            n_errors++;
            $display("FAIL err_clr: err=%b err_addr=%0d required 0 / 0", err, err_addr);
        end
        err_clr = 1'b1; read = 1'b1; r_addr = 4'd12;
        tick();
        idle_inputs();
        n_checks++;
        if (err !== 1'b1 || err_addr !== 4'd12) begin
            n_errors++;
            $display("FAIL clr_vs_new_err: err=%b err_addr=%0d required 1 / 12", err, err_addr);
        end
        err_clr = 1'b1;
        tick();
        idle_inputs();
        read = 1'b1; r_addr = 4'd13; write = 1'b1; w_addr = 4'd15;
        tick();
        idle_inputs();
        n_checks++;
        if (err !== 1'b1 || err_addr !== 4'd13) begin
            n_errors++;
            $display("FAIL read_priority: err=%b err_addr=%0d required 1 / 13", err, err_addr);
        end
        write = 1'b1; w_addr = 4'd14;
        tick();
        idle_inputs();
        n_checks++;
        if (err_addr !== 4'd13) begin
            n_errors++;
            $display("FAIL first_only: err_addr=%0d required 13", err_addr);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        write = 1'b1; w_addr = 4'd4; w_data = 64'h77;
        tick();
        idle_inputs();
        read = 1'b1; r_addr = 4'd13;
        tick();
        read = 1'b1; r_addr = 4'd4;
        tick();
        idle_inputs();
        n_checks++;
        if (r_data !== 64'h77 || err !== 1'b1 || rd_count !== 16'd2) begin
            n_errors++;
            $display("FAIL mid_setup: r_data=%h err=%b rd=%0d required 77 / 1 / 2", r_data, err, rd_count);
        end
        rst_ni = 1'b0;
        #1;
        n_checks++;
        if (r_data !== '0 || r_valid !== 1'b0 || ready !== 1'b0 || err !== 1'b0 ||
            err_addr !== '0 || rd_count !== '0 || wr_count !== '0) begin
            n_errors++;
            $display("FAIL async_reset: r_data=%h r_valid=%b ready=%b err=%b err_addr=%0d rd=%0d wr=%0d, required all zero",
                     r_data, r_valid, ready, err, err_addr, rd_count, wr_count);
        end
        tick();
        rst_ni = 1'b1;
        read = 1'b1; r_addr = 4'd4; write = 1'b1; w_addr = 4'd4; w_data = 64'h99;
        repeat (5) tick();
        rst_ni = 1'b0;
        #1;
        n_checks++;
        if (ready !== 1'b0 || r_valid !== 1'b0 || rd_count !== '0 || wr_count !== '0) begin
            n_errors++;
            $display("FAIL reset_mid_clear: ready=%b r_valid=%b rd=%0d wr=%0d required 0", ready, r_valid, rd_count, wr_count);
        end
        tick();
        rst_ni = 1'b1;
        for (int i = 0; i < 12; i++) begin
            n_checks++;
            if (ready !== 1'b0 || r_valid !== 1'b0 || rd_count !== '0 || wr_count !== '0 || err !== 1'b0) begin
                n_errors++;
                $display("FAIL strobes_in_clear cycle %0d: ready=%b r_valid=%b rd=%0d wr=%0d err=%b required 0",
                         i + 1, ready, r_valid, rd_count, wr_count, err);
            end
            tick();
        end
        n_checks++;
        if (ready !== 1'b1 || rd_count !== '0) begin
            n_errors++;
            $display("FAIL ready_after_restart: ready=%b rd=%0d required 1 / 0", ready, rd_count);
        end
        write = 1'b0; read = 1'b1; r_addr = 4'd4;
        tick();
        idle_inputs();
        n_checks++;
        if (r_data !== '0 || r_valid !== 1'b1 || rd_count !== 16'd1 || wr_count !== '0) begin
            n_errors++;
            $display("FAIL clear_wins: r_data=%h r_valid=%b rd=%0d wr=%0d required 0 / 1 / 1 / 0",
                     r_data, r_valid, rd_count, wr_count);
        end
    endtask

    task automatic test_saturate();
        do_reset();
        read = 1'b1; r_addr = 4'd0;
        repeat (20) tick();
        idle_inputs();
        n_checks++;
        if (rd_count4 !== 4'd15 || rd_count !== 16'd20 || wr_count4 !== 4'd0) begin
            n_errors++;
            $display("FAIL saturate: rd_count4=%0d rd_count=%0d wr_count4=%0d required 15 / 20 / 0",
                     rd_count4, rd_count, wr_count4);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_same_cycle();
        test_out_of_range();
        test_reset_mid();
        test_saturate();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/calc_mem_responder.md
CALC_MEM_RESPONDER -- requirements
Module: calc_mem_responder

Interface
REQ-001 SHALL import calculator_pkg::* for ADDR_W and MEM_WORD_SIZE.
REQ-002 SHALL have parameter DEPTH, default 2**ADDR_W, number of implemented words; legal range 2..2**ADDR_W.
REQ-003 SHALL have parameter CNT_W, default 16, width of the access counters.
REQ-004 SHALL have port clk_i  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port read  input  1  read strobe from controller.
REQ-007 SHALL have port r_addr  input  ADDR_W  read address.
REQ-008 SHALL have port r_data  output  MEM_WORD_SIZE  registered read data.
REQ-009 SHALL have port r_valid  output  1  one-cycle pulse, r_data updated this cycle.
REQ-010 SHALL have port write  input  1  write strobe from controller.
REQ-011 SHALL have port w_addr  input  ADDR_W  write address.
REQ-012 SHALL have port w_data  input  MEM_WORD_SIZE  write data.
REQ-013 SHALL have port ready  output  1  high when memory initialised and accepting accesses.
REQ-014 SHALL have port err  output  1  sticky out-of-range access flag.
REQ-015 SHALL have port err_addr  output  ADDR_W  address of first out-of-range access.
REQ-016 SHALL have port err_clr  input  1  synchronous clear of err/err_addr.
REQ-017 SHALL have ports rd_count, wr_count  output  CNT_W  accepted read/write counts.

Function
REQ-018 SHALL implement FSM states S_CLEAR and S_READY; reset enters S_CLEAR.
REQ-019 In S_CLEAR SHALL write zero to word clr_ptr each cycle, clr_ptr 0..DEPTH-1, then enter S_READY; clear takes exactly DEPTH cycles after reset release.
REQ-020 In S_CLEAR SHALL ignore read/write strobes: no memory update, r_valid=0, counters and err unchanged.
REQ-021 ready SHALL be 0 in S_CLEAR, 1 in S_READY; S_READY SHALL persist until reset.
REQ-022 Read accepted in cycle N (S_READY, read=1) SHALL drive r_data=mem[r_addr] and r_valid=1 in cycle N+1 (one-cycle latency).
REQ-023 r_data SHALL hold its value until the next accepted read; r_valid SHALL be 1 only the cycle after an accepted read.
REQ-024 Write accepted in cycle N SHALL update mem[w_addr]=w_data at the cycle-N edge; visible to reads issued in N+1.
REQ-025 Read and write to same in-range address in same cycle SHALL be write-first: r_data = w_data.
REQ-026 Read and write to different addresses in same cycle SHALL both complete independently.
REQ-027 Address >= DEPTH SHALL be out-of-range: write dropped, read returns r_data=0 with r_valid=1.
REQ-028 Out-of-range access SHALL set err=1; err_addr SHALL capture the first offending address only (read address priority if both in one cycle).
REQ-029 err_clr=1 SHALL clear err and err_addr next cycle; a simultaneous new error SHALL win (err=1, new address captured).
REQ-030 rd_count/wr_count SHALL increment by 1 per accepted strobe (in-range or not) and saturate at all-ones.

Reset
REQ-031 rst_ni low SHALL immediately force: state S_CLEAR, clr_ptr 0, r_data 0, r_valid 0, ready 0, err 0, err_addr 0, rd_count 0, wr_count 0.
REQ-032 Reset asserted mid-clear or mid-operation SHALL abort the operation and restart the full clear sequence on release; memory contents not relied upon until ready=1.
REQ-033 Reset release SHALL take effect on the first clock edge after rst_ni rises.

Verification (bench DEPTH=12)
REQ-034 Release reset, no strobes -> ready=0 for 12 cycles, ready=1 cycle 13; read all 12 addresses -> r_data=0 each.
REQ-035 Write 0x1122_3344_5566_7788 to addr 3, read addr 3 next cycle -> r_data=0x1122_3344_5566_7788, r_valid=1 exactly one cycle later.
REQ-036 Same cycle write 0xAA to addr 5 and read addr 5 -> r_data=0xAA next cycle; wr_count=1, rd_count=1.
REQ-037 Write addr 14 then read addr 13 -> write dropped, r_data=0, err=1, err_addr=14; err_clr -> err=0, err_addr=0.
REQ-038 Assert rst_ni low at clear cycle 6, release -> outputs zero immediately, ready rises 12 cycles after release; strobes during clear leave counters at 0.
REQ-039 With CNT_W=4, issue 20 reads -> rd_count=15 (saturated).
